// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, FSM states and bus select codes shared by the control FSM, datapath and bus mux
package proc_pkg;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [3:0] SEL_DIN = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;
  typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} state_t;
  function automatic logic is_alu(input logic [2:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/proc_bus_ctrl_dec3to8.sv
// dec3to8: 3-bit to one-hot-8 decoder with enable
module dec3to8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);
  assign y = en ? 8'd1 << a : 8'd0;
endmodule

// File: rtl/proc_bus_ctrl.sv
// proc_bus_ctrl: multicycle control FSM driving register/A/G enables and the bus mux select
// Defining PROC_BUS_CTRL_COUNT_EN adds the instr_count completed-instruction counter.
module proc_bus_ctrl import proc_pkg::*; #(
  parameter int SEL_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [8:0]       din,
  output logic             ir_load,
  output logic [SEL_W-1:0] bus_sel,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic             addsub,
  output logic             done
`ifdef PROC_BUS_CTRL_COUNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);
  state_t     state;
  logic [8:0] ir;
  logic [2:0] op, rx, ry;
  logic       alu, r_en;
  logic [3:0] sel;
  assign op  = ir[8:6];
  assign rx  = ir[5:3];
  assign ry  = ir[2:0];
  assign alu = is_alu(op);
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else
      case (state)
        T0: if (run) begin
          ir    <= din;
          state <= T1;
        end
        T1: state <= alu ? T2 : T0;
        T2: state <= T3;
        default: state <= T0;
      endcase
  always_comb begin
    ir_load = state == T0 && run;
    a_in    = state == T1 && alu;
    g_in    = state == T2;
    addsub  = g_in && op == OP_SUB;
    done    = (state == T1 && !alu) || state == T3;
    r_en    = (state == T1 && (op == OP_MV || op == OP_MVI)) || state == T3;
    sel     = state == T3                 ? SEL_G :
              state == T2                 ? {1'b0, ry} :
              state == T1 && op == OP_MVI ? SEL_DIN :
              state == T1 && op == OP_MV  ? {1'b0, ry} :
              a_in                        ? {1'b0, rx} : 4'd0;
  end
  assign bus_sel = SEL_W'(sel);
  dec3to8 u_dec (.en(r_en), .a(rx), .y(r_in));
`ifdef PROC_BUS_CTRL_COUNT_EN
  always_ff @(posedge clk)
    if (!resetn) instr_count <= '0;
    else if (done) instr_count <= instr_count + CNT_W'(1);
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_proc_bus_ctrl.sv
// tb_proc_bus_ctrl: lockstep instruction-level model plus literal checks for proc_bus_ctrl
module tb_proc_bus_ctrl;
  localparam int CW = 2;
  typedef struct packed {
    logic       ir_load;
    logic [3:0] sel;
    logic [7:0] r;
    logic       a, g, as, done;
  } vec_t;
  typedef struct {
    bit   v;
    vec_t e;
    bit   le;
    vec_t l;
    logic rn;
  } ent_t;
  logic clk = 0, resetn = 0, run = 0;
  logic [8:0] din = '0;
  logic ir_load, a_in, g_in, addsub, done;
  logic [3:0] bus_sel;
  logic [7:0] r_in;
  vec_t got;
  ent_t q[$];
  int total = 0, bad = 0, cyc_n = 0;
  int exp_cnt = 0;
`ifdef PROC_BUS_CTRL_COUNT_EN
  logic [CW-1:0] instr_count;
`endif
  proc_bus_ctrl #(.SEL_W(4), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din), .ir_load(ir_load),
    .bus_sel(bus_sel), .r_in(r_in), .a_in(a_in), .g_in(g_in), .addsub(addsub), .done(done)
`ifdef PROC_BUS_CTRL_COUNT_EN
    , .instr_count(instr_count)
`endif
  );
  always #5 clk = ~clk;
  assign got = {ir_load, bus_sel, r_in, a_in, g_in, addsub, done};
  function automatic vec_t lv(logic il, logic [3:0] s, logic [7:0] r, logic a, logic g, logic as, logic dn);
    return {il, s, r, a, g, as, dn};
  endfunction
  // step s of instruction d: 0 = fetch cycle, 1..3 = execution cycles
  function automatic vec_t model(logic [8:0] d, int s);
    logic [2:0] op, rx, ry;
    logic [7:0] oh;
    op = d[8:6];
    rx = d[5:3];
    ry = d[2:0];
    oh = 8'd1 << rx;
    if (s == 0) return lv(1, 0, 0, 0, 0, 0, 0);
    if (s == 2) return lv(0, {1'b0, ry}, 0, 0, 1, op == 3'd3, 0);
    if (s == 3) return lv(0, 4'd9, oh, 0, 0, 0, 1);
    case (op)
      3'd0: return lv(0, {1'b0, ry}, oh, 0, 0, 0, 1);
      3'd1: return lv(0, 4'd8, oh, 0, 0, 0, 1);
      3'd2, 3'd3: return lv(0, {1'b0, rx}, 0, 1, 0, 0, 0);
      default: return lv(0, 0, 0, 0, 0, 0, 1);
    endcase
  endfunction
  task automatic cyc(bit v, logic rn, logic r, logic [8:0] d, vec_t e, bit le = 0, vec_t l = '0);
    @(posedge clk);
    #1;
    resetn = rn;
    run = r;
    din = d;
    q.push_back('{v, e, le, l, rn});
  endtask
  task automatic idle(int n);
    repeat (n) cyc(1, 1, 0, 9'($urandom), '0);
  endtask
  task automatic instr(logic [8:0] d, bit hold, bit le = 0, vec_t l0 = '0, vec_t l1 = '0, vec_t l2 = '0, vec_t l3 = '0);
    vec_t ls[4];
    int n;
    ls = '{l0, l1, l2, l3};
    n = (d[8:7] == 2'b01) ? 4 : 2;
    for (int s = 0; s < n; s++)
      cyc(1, 1, s == 0 ? 1'b1 : hold, s == 0 ? d : 9'($urandom), model(d, s), le, ls[s]);
  endtask
  task automatic lit_chk(string name, int g, int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, g, e);
    end
  endtask
  always @(negedge clk) begin
    ent_t t;
    cyc_n++;
    if (q.size() > 0) begin
      t = q.pop_front();
      if (t.v) begin
        total++;
        if (got !== t.e) begin
          bad++;
          $display("FAIL model cyc=%0d got=%h exp=%h", cyc_n, got, t.e);
        end
        if (t.le) begin
          total++;
          if (got !== t.l) begin
            bad++;
            $display("FAIL literal cyc=%0d got=%h exp=%h", cyc_n, got, t.l);
          end
        end
`ifdef PROC_BUS_CTRL_COUNT_EN
        total++;
        if (instr_count !== CW'(exp_cnt)) begin
          bad++;
          $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc_n, instr_count, CW'(exp_cnt));
        end
`endif
      end
      exp_cnt = !t.rn ? 0 : (exp_cnt + int'(t.e.done)) % (1 << CW);
    end
  end
  initial begin
    cyc(0, 0, 0, '0, '0);
    cyc(1, 0, 0, 9'h1ff, '0, 1, '0);
    cyc(1, 1, 0, 9'h1ff, '0, 1, '0);
    idle(5);
    instr(9'b001_010_000, 0, 1, lv(1, 0, 0, 0, 0, 0, 0), lv(0, 8, 8'b0000_0100, 0, 0, 0, 1));
    idle(1);
    instr(9'b000_101_011, 0, 1, lv(1, 0, 0, 0, 0, 0, 0), lv(0, 3, 8'b0010_0000, 0, 0, 0, 1));
    idle(1);
    instr(9'b011_001_110, 1, 1, lv(1, 0, 0, 0, 0, 0, 0), lv(0, 1, 0, 1, 0, 0, 0),
          lv(0, 6, 0, 0, 1, 1, 0), lv(0, 9, 8'b0000_0010, 0, 0, 0, 1));
    idle(1);
    instr(9'b010_100_111, 0, 1, lv(1, 0, 0, 0, 0, 0, 0), lv(0, 4, 0, 1, 0, 0, 0),
          lv(0, 7, 0, 0, 1, 0, 0), lv(0, 9, 8'b0001_0000, 0, 0, 0, 1));
    instr(9'b010_011_011, 1);
    instr(9'b100_110_001, 1, 1, lv(1, 0, 0, 0, 0, 0, 0), lv(0, 0, 0, 0, 0, 0, 1));
    instr(9'b001_111_000, 0);
    instr(9'b000_000_111, 0);
    idle(2);
    cyc(1, 1, 1, 9'b010_110_010, model(9'b010_110_010, 0));
    cyc(1, 1, 1, 9'($urandom), model(9'b010_110_010, 1));
    cyc(1, 0, 0, 9'($urandom), model(9'b010_110_010, 2));
    cyc(1, 1, 0, 9'($urandom), '0, 1, '0);
    idle(1);
    instr(9'b001_110_000, 0, 1, lv(1, 0, 0, 0, 0, 0, 0), lv(0, 8, 8'b0100_0000, 0, 0, 0, 1));
    idle(1);
    cyc(1, 0, 0, '0, '0);
    idle(1);
    instr(9'b000_010_001, 1);
    instr(9'b010_001_001, 1);
    instr(9'b111_000_000, 1);
    idle(1);
`ifdef PROC_BUS_CTRL_COUNT_EN
    @(negedge clk);
    lit_chk("count_after3", int'(instr_count), 3);
`endif
    instr(9'b001_000_000, 0);
    idle(1);
`ifdef PROC_BUS_CTRL_COUNT_EN
    @(negedge clk);
    lit_chk("count_wrap", int'(instr_count), 0);
`endif
    idle(2);
    @(negedge clk);
    #1;
    lit_chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
